// File: rtl/alarm_buzzer_pkg.sv
// Shared types and defaults for the alarm buzzer driver.
// The optional button debounce is enabled by defining ALARM_BUZZER_DEBOUNCE_EN.
package alarm_buzzer_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RING_ON  = 3'd1,
        RING_OFF = 3'd2,
        SNOOZE   = 3'd3,
        DONE     = 3'd4
    } state_t;

    localparam int DEF_TICK_DIV    = 50000;
    localparam int DEF_TONE_HALF   = 12500;
    localparam int DEF_ON_MS       = 250;
    localparam int DEF_OFF_MS      = 250;
    localparam int DEF_TIMEOUT_MS  = 60000;
    localparam int DEF_SNOOZE_MS   = 300000;
    localparam int DEF_DEBOUNCE_MS = 20;

    // Bits needed to hold the values 0..value.
    function automatic int cnt_width(input int value);
        return (value < 1) ? 1 : $clog2(value + 1);
    endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Button conditioner: 2-FF synchronizer, optional debounce, one-cycle press pulse.
// Debounce is built only when ALARM_BUZZER_DEBOUNCE_EN is defined.
module btn_sync_edge
    import alarm_buzzer_pkg::*;
#(
    parameter int DEBOUNCE_MS = DEF_DEBOUNCE_MS
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn,
    input  logic tick,
    output logic press
);

    logic sync1_reg;
    logic sync2_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
        end else begin
            sync1_reg <= btn;
            sync2_reg <= sync1_reg;
        end
    end

`ifdef ALARM_BUZZER_DEBOUNCE_EN
    localparam int DEB_W = cnt_width(DEBOUNCE_MS);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_MS - 1);

    logic             level_reg;
    logic [DEB_W-1:0] deb_cnt_reg;
    logic             accept;

    // A new level is accepted on the tick that completes DEBOUNCE_MS stable ticks.
    assign accept = (sync2_reg != level_reg) && tick && (deb_cnt_reg == DEB_LAST);
    assign press  = accept && sync2_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level_reg   <= 1'b0;
            deb_cnt_reg <= '0;
        end else if (sync2_reg == level_reg) begin
            deb_cnt_reg <= '0;
        end else if (accept) begin
            level_reg   <= sync2_reg;
            deb_cnt_reg <= '0;
        end else if (tick) begin
            deb_cnt_reg <= deb_cnt_reg + DEB_W'(1);
        end
    end
`else
    logic prev_reg;
    logic unused_cfg;

    assign press      = sync2_reg && !prev_reg;
    assign unused_cfg = tick ^ (DEBOUNCE_MS == 0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_reg <= 1'b0;
        end else begin
            prev_reg <= sync2_reg;
        end
    end
`endif

endmodule

// File: rtl/alarm_buzzer_driver.sv
// Turns the ALARM PIO level into a beeping square-wave tone with snooze, stop and timeout.
// Button debounce is optional via ALARM_BUZZER_DEBOUNCE_EN (see btn_sync_edge).
module alarm_buzzer_driver
    import alarm_buzzer_pkg::*;
#(
    parameter int TICK_DIV    = DEF_TICK_DIV,
    parameter int TONE_HALF   = DEF_TONE_HALF,
    parameter int ON_MS       = DEF_ON_MS,
    parameter int OFF_MS      = DEF_OFF_MS,
    parameter int TIMEOUT_MS  = DEF_TIMEOUT_MS,
    parameter int SNOOZE_MS   = DEF_SNOOZE_MS,
    parameter int DEBOUNCE_MS = DEF_DEBOUNCE_MS
) (
    input  logic clk,
    input  logic reset_n,
    input  logic alarm_in,
    input  logic snooze_btn,
    input  logic stop_btn,
    output logic buzzer_out,
    output logic led_out,
    output logic snoozing
);

    localparam int MS_MAX = (SNOOZE_MS > ON_MS)
                          ? ((SNOOZE_MS > OFF_MS) ? SNOOZE_MS : OFF_MS)
                          : ((ON_MS > OFF_MS) ? ON_MS : OFF_MS);
    localparam int TICK_W = cnt_width(TICK_DIV);
    localparam int TONE_W = cnt_width(TONE_HALF);
    localparam int MS_W   = cnt_width(MS_MAX);
    localparam int TO_W   = cnt_width(TIMEOUT_MS);

    localparam logic [TICK_W-1:0] TICK_LAST   = TICK_W'(TICK_DIV - 1);
    localparam logic [TONE_W-1:0] TONE_LAST   = TONE_W'(TONE_HALF - 1);
    localparam logic [MS_W-1:0]   ON_LAST     = MS_W'(ON_MS - 1);
    localparam logic [MS_W-1:0]   OFF_LAST    = MS_W'(OFF_MS - 1);
    localparam logic [MS_W-1:0]   SNOOZE_LAST = MS_W'(SNOOZE_MS - 1);
    localparam logic [TO_W-1:0]   TO_LAST     = TO_W'(TIMEOUT_MS - 1);

    state_t              state_reg, state_next;
    logic [TICK_W-1:0]   tick_cnt_reg;
    logic [TONE_W-1:0]   tone_cnt_reg;
    logic [MS_W-1:0]     ms_cnt_reg;
    logic [TO_W-1:0]     to_cnt_reg;
    logic                phase_reg;
    logic                alarm_prev_reg;
    logic                tick;
    logic                ms_last;
    logic                to_last;
    logic                ringing;
    logic                snooze_press;
    logic                stop_press;

    btn_sync_edge #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_snooze (
        .clk(clk), .reset_n(reset_n), .btn(snooze_btn), .tick(tick), .press(snooze_press)
    );

    btn_sync_edge #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_stop (
        .clk(clk), .reset_n(reset_n), .btn(stop_btn), .tick(tick), .press(stop_press)
    );

    assign tick    = (tick_cnt_reg == TICK_LAST);
    assign to_last = (to_cnt_reg == TO_LAST);
    assign ringing = (state_reg == RING_ON) || (state_reg == RING_OFF);

    always_comb begin
        ms_last = 1'b0;
        case (state_reg)
            RING_ON:  ms_last = (ms_cnt_reg == ON_LAST);
            RING_OFF: ms_last = (ms_cnt_reg == OFF_LAST);
            SNOOZE:   ms_last = (ms_cnt_reg == SNOOZE_LAST);
            default:  ms_last = 1'b0;
        endcase
    end

    // Events in priority order: alarm drop, stop, snooze, timeout, cadence.
    always_comb begin
        state_next = state_reg;
        if (!alarm_in) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: if (!alarm_prev_reg) state_next = RING_ON;
                RING_ON, RING_OFF: begin
                    if (stop_press)             state_next = DONE;
                    else if (snooze_press)      state_next = SNOOZE;
                    else if (tick && to_last)   state_next = DONE;
                    else if (tick && ms_last)   state_next = (state_reg == RING_ON) ? RING_OFF : RING_ON;
                end
                SNOOZE: begin
                    if (stop_press)             state_next = DONE;
                    else if (tick && ms_last)   state_next = RING_ON;
                end
                DONE:    state_next = DONE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            alarm_prev_reg <= 1'b0;
            tick_cnt_reg   <= '0;
            tone_cnt_reg   <= '0;
            ms_cnt_reg     <= '0;
            to_cnt_reg     <= '0;
            phase_reg      <= 1'b0;
            buzzer_out     <= 1'b0;
            led_out        <= 1'b0;
            snoozing       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            alarm_prev_reg <= alarm_in;

            // Prescaler and cadence restart on every transition so durations are exact.
            if (state_next != state_reg) begin
                tick_cnt_reg <= '0;
                ms_cnt_reg   <= '0;
            end else begin
                tick_cnt_reg <= tick ? '0 : tick_cnt_reg + TICK_W'(1);
                if (tick && (ringing || state_reg == SNOOZE))
                    ms_cnt_reg <= ms_cnt_reg + MS_W'(1);
            end

            // Timeout restarts on each fresh ring and holds its value through SNOOZE.
            if ((state_reg == IDLE || state_reg == SNOOZE) && state_next == RING_ON)
                to_cnt_reg <= '0;
            else if (ringing && tick)
                to_cnt_reg <= to_last ? '0 : to_cnt_reg + TO_W'(1);

            if (state_next == RING_ON && state_reg != RING_ON) begin
                tone_cnt_reg <= '0;
                phase_reg    <= 1'b1;
            end else if (state_reg == RING_ON) begin
                if (tone_cnt_reg == TONE_LAST) begin
                    tone_cnt_reg <= '0;
                    phase_reg    <= !phase_reg;
                end else begin
                    tone_cnt_reg <= tone_cnt_reg + TONE_W'(1);
                end
            end

            // Tone lags the state by one edge but is cut on the edge that leaves RING_ON.
            buzzer_out <= (state_reg == RING_ON) && (state_next == RING_ON) && phase_reg;
            led_out    <= (state_next == RING_ON) || (state_next == RING_OFF) || (state_next == SNOOZE);
            snoozing   <= (state_next == SNOOZE);
        end
    end

endmodule

// File: tb/tb_alarm_buzzer_driver.sv
// Directed bench for alarm_buzzer_driver with small timing parameters.
module tb_alarm_buzzer_driver;

    logic clk;
    logic reset_n;
    logic alarm_in;
    logic snooze_btn;
    logic stop_btn;
    logic buzzer_out;
    logic led_out;
    logic snoozing;

    int total = 0;
    int bad   = 0;

    alarm_buzzer_driver #(
        .TICK_DIV(10), .TONE_HALF(3), .ON_MS(4), .OFF_MS(2),
        .TIMEOUT_MS(20), .SNOOZE_MS(8), .DEBOUNCE_MS(2)
    ) dut (
        .clk(clk), .reset_n(reset_n), .alarm_in(alarm_in),
        .snooze_btn(snooze_btn), .stop_btn(stop_btn),
        .buzzer_out(buzzer_out), .led_out(led_out), .snoozing(snoozing)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end else begin
            $display("chk  %s got=%0d ok", tag, got);
        end
    endtask

    // Advance n rising edges and settle just after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drop then raise alarm_in; returns just after the edge that enters RING_ON.
    task automatic restart();
        alarm_in = 1'b0;
        step(2);
        alarm_in = 1'b1;
        step(1);
    endtask

    // Expected buzzer j edges after entering RING_ON with a 60-cycle cadence.
    function automatic logic exp_tone(input int j);
        int p;
        p = j % 60;
        if (p == 0 || p > 39) return 1'b0;
        return (((p - 1) / 3) % 2) == 0;
    endfunction

    initial begin
        int hits;
        reset_n = 1'b0; alarm_in = 1'b0; snooze_btn = 1'b0; stop_btn = 1'b0;
        step(2);
        check("rst_buzzer", buzzer_out, 0);
        check("rst_led", led_out, 0);
        check("rst_snoozing", snoozing, 0);
        reset_n = 1'b1;
        step(2);

        // Ring, cadence and tone: at edge k, j counts edges since entry.
        restart();
        check("ring_led", led_out, 1);
        check("ring_latency", buzzer_out, 0);
        for (int j = 1; j <= 66; j++) begin
            step(1);
            check($sformatf("tone_j%0d", j), buzzer_out, exp_tone(j));
            if (j % 20 == 0) check($sformatf("led_j%0d", j), led_out, 1);
        end

        // Timeout after 200 ringing cycles, no retrigger while held high.
        step(133);
        check("to_before", led_out, 1);
        step(1);
        check("to_led", led_out, 0);
        check("to_buzzer", buzzer_out, 0);
        hits = 0;
        for (int j = 0; j < 100; j++) begin
            step(1);
            if (led_out || buzzer_out) hits++;
        end
        check("done_hold", hits, 0);
        restart();
        check("rering_led", led_out, 1);
        step(1);
        check("rering_buzzer", buzzer_out, 1);

`ifndef ALARM_BUZZER_DEBOUNCE_EN
        // Snooze from RING_ON at k+125 with 12 timeout ticks already counted.
        restart();
        step(125);
        check("snz_pre", snoozing, 0);
        snooze_btn = 1'b1;
        step(2);
        check("snz_lat2", snoozing, 0);
        step(1);
        check("snz_on", snoozing, 1);
        check("snz_buzzer", buzzer_out, 0);
        check("snz_led", led_out, 1);
        snooze_btn = 1'b0;
        step(5);
        snooze_btn = 1'b1;
        step(4);
        snooze_btn = 1'b0;
        check("snz_second", snoozing, 1);
        step(70);
        check("snz_end_m1", snoozing, 1);
        step(1);
        check("snz_end", snoozing, 0);
        check("snz_end_led", led_out, 1);
        step(1);
        check("snz_rering", buzzer_out, 1);
        step(91);
        check("to_cleared", led_out, 1);
        step(107);
        check("to2_before", led_out, 1);
        step(1);
        check("to2_done", led_out, 0);

        // Stop beats snooze in the same cycle.
        restart();
        stop_btn = 1'b1; snooze_btn = 1'b1;
        step(2);
        check("prio_pre", led_out, 1);
        step(1);
        check("prio_stop_led", led_out, 0);
        check("prio_stop_snz", snoozing, 0);
        stop_btn = 1'b0; snooze_btn = 1'b0;

        // Alarm drop beats stop: IDLE allows an immediate re-ring, DONE would not.
        restart();
        stop_btn = 1'b1;
        step(2);
        alarm_in = 1'b0;
        step(1);
        check("prio_drop_led", led_out, 0);
        alarm_in = 1'b1; stop_btn = 1'b0;
        step(1);
        check("prio_idle", led_out, 1);
`else
        // Debounced snooze: a 1-tick glitch is ignored, a 3-tick press is taken.
        restart();
        step(2);
        snooze_btn = 1'b1;
        step(10);
        snooze_btn = 1'b0;
        step(40);
        check("deb_glitch", snoozing, 0);
        snooze_btn = 1'b1;
        hits = 0;
        for (int j = 0; j < 80 && hits == 0; j++) begin
            step(1);
            if (snoozing) hits = 1;
        end
        snooze_btn = 1'b0;
        check("deb_press", hits, 1);
`endif

        // Asynchronous reset during a high tone phase.
        restart();
        step(1);
        check("rst_mid_pre", buzzer_out, 1);
        #2;
        reset_n = 1'b0; alarm_in = 1'b0;
        #1;
        check("rst_mid_buzzer", buzzer_out, 0);
        check("rst_mid_led", led_out, 0);
        check("rst_mid_snz", snoozing, 0);
        step(2);
        reset_n = 1'b1;
        step(20);
        check("rst_idle", led_out, 0);
        alarm_in = 1'b1;
        step(1);
        check("rst_rering_led", led_out, 1);
        step(1);
        check("rst_rering_buzzer", buzzer_out, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alarm_buzzer_driver.md
Name: alarm_buzzer_driver

Overview:
Sits directly downstream of the ALARM PIO output bit and turns its level into an audible alarm pattern.
- On a rising edge of the alarm level it drives a square-wave tone, gated by an on/off beep cadence.
- Supports snooze and stop push-buttons, plus an auto-timeout.
- Outputs feed the board buzzer pin and a status LED.

Parameters:
- TICK_DIV, 50000: clk cycles per 1 ms tick (50 MHz clock).
- TONE_HALF, 12500: clk cycles per tone half-period (2 kHz tone).
- ON_MS, 250: beep-on duration in ticks.
- OFF_MS, 250: beep-off duration in ticks.
- TIMEOUT_MS, 60000: total ringing time, in ticks, before auto-stop.
- SNOOZE_MS, 300000: snooze duration in ticks.
- DEBOUNCE_MS, 20: button stable time in ticks (used only with the optional feature).

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset
- alarm_in  in  1  alarm level from the PIO out_port; synchronous to clk
- snooze_btn  in  1  raw snooze button, active-high, asynchronous
- stop_btn  in  1  raw stop button, active-high, asynchronous
- buzzer_out  out  1  tone drive to the buzzer
- led_out  out  1  high in RING_ON, RING_OFF and SNOOZE
- snoozing  out  1  high in SNOOZE only

Behaviour:
- Reset: reset_n is asynchronous, active-low; clock is clk.
  - State goes to IDLE; all counters clear.
  - buzzer_out, led_out and snoozing are all 0.
  - alarm_in history register clears to 0.
  - Button synchronizers clear to 0.
  - Asserting reset mid-ring silences the buzzer immediately, with no drain.
- All outputs are registered.
- Buttons:
  - Each button passes through a 2-FF synchronizer, then rising-edge detection, producing a one-cycle press pulse.
  - Latency from raw input high to the state change is 3 clk cycles.
- Prescaler:
  - Generates a 1-cycle tick every TICK_DIV clocks.
  - Restarts at 0 on every state transition, so every duration is exactly N*TICK_DIV clocks.
- State machine (IDLE, RING_ON, RING_OFF, SNOOZE, DONE):
  - IDLE: an alarm_in rising edge (sampled low then high) moves to RING_ON. This clears the timeout counter and sets the tone phase to 1.
  - RING_ON: after ON_MS ticks, move to RING_OFF.
  - RING_OFF: after OFF_MS ticks, move to RING_ON.
  - SNOOZE: after SNOOZE_MS ticks, move to RING_ON and clear the timeout counter.
  - RING_ON / RING_OFF: the timeout counter counts ticks in both states; on reaching TIMEOUT_MS, move to DONE. The counter holds its value across SNOOZE.
  - DONE: stay until alarm_in is low, then move to IDLE. A new rising edge is required to ring again.
- Event priority, applied every cycle:
  1. alarm_in low: from any state, go to IDLE.
  2. Stop press: from RING_ON, RING_OFF or SNOOZE, go to DONE.
  3. Snooze press: from RING_ON or RING_OFF, go to SNOOZE. Ignored in SNOOZE.
  4. Timeout.
  5. Cadence expiry.
- Latency: alarm_in rise sampled at edge k puts state in RING_ON after edge k; buzzer_out is 1 after edge k+1.
- Tone:
  - In RING_ON, the phase toggles every TONE_HALF clocks.
  - The tone counter resets on entry to RING_ON, so each beep starts high.
  - buzzer_out = phase in RING_ON, otherwise 0 (updated one edge after the state).
- Width rules:
  - Counters are sized by $clog2(param+1).
  - Compares are equality against param-1 with terminal reset; there is no wrap past terminal.
- alarm_in held high continuously never retriggers after DONE.

Optional Feature:
- Macro ALARM_BUZZER_DEBOUNCE_EN.
- Defined: after the synchronizer, a button level is accepted only once it has been stable for DEBOUNCE_MS consecutive ticks. A press pulse is issued on the accepted 0->1 transition. Latency is 3 cycles plus the debounce time.
- Undefined: no debounce; the press pulse is issued directly from the synchronized edge, and DEBOUNCE_MS is unused.

Decomposition:
- Package alarm_buzzer_pkg holds:
  - the state enum type (IDLE, RING_ON, RING_OFF, SNOOZE, DONE, 3-bit encoding);
  - default parameter constants;
  - a counter-width helper function.
- Sub-module btn_sync_edge (synchronizer, optional debounce, edge pulse) is instantiated twice, once per button.
- The top module holds the state machine, prescaler, cadence, timeout and tone logic.

Test Plan:
All scenarios use bench parameters TICK_DIV=10, TONE_HALF=3, ON_MS=4, OFF_MS=2, TIMEOUT_MS=20, SNOOZE_MS=8, DEBOUNCE_MS=2.
1. Ring and cadence: raise alarm_in -> buzzer_out toggles every 3 cycles for 40 cycles, then stays 0 for 20 cycles, then repeats; led_out=1 throughout.
2. Timeout: hold alarm_in high -> after 200 ringing cycles state is DONE with buzzer_out=0 and led_out=0; no restart while alarm_in stays high; drop then re-raise alarm_in -> ringing restarts.
3. Snooze: press snooze during RING_ON -> 3 cycles later snoozing=1 and buzzer_out=0; after 80 cycles rings again with timeout cleared; a second snooze press in SNOOZE is ignored.
4. Priority: assert stop and snooze in the same cycle -> DONE. Drop alarm_in in the same cycle as a stop press -> IDLE.
5. Reset mid-ring: pulse reset_n low during a high tone phase -> buzzer_out, led_out and snoozing are 0 immediately (asynchronously); stays IDLE until a fresh alarm_in rising edge.
6. With ALARM_BUZZER_DEBOUNCE_EN: a 1-tick glitch on snooze_btn is ignored; a 3-tick press enters SNOOZE.
